// File: rtl/lane_round_engine_pkg.sv
// Shared definitions for the lane round engine: FSM codes, LFSR taps,
// lane index sizing and two-digit BCD arithmetic helpers.
package lane_round_engine_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SHOW     = 3'd2;
    localparam logic [2:0] ST_WAIT_CLR = 3'd3;
    localparam logic [2:0] ST_OVER     = 3'd4;

    // Taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int lane_idx_w(input int lanes);
        return $clog2(lanes);
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00) return v;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/lane_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes only the low bits used as a
// lane index so the full register stays internal.
module lane_lfsr
    import lane_round_engine_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          IDX_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [IDX_W-1:0] idx
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign idx = lfsr_q[IDX_W-1:0];

endmodule

// File: rtl/lane_round_engine.sv
// Round loop for the lane reaction game: pattern build, countdown, hit/miss
// judgement, lives, BCD score and BCD game timer.
module lane_round_engine
    import lane_round_engine_pkg::*;
#(
    parameter int          LANES      = 16,
    parameter int          MAX_HITS   = 3,
    parameter int          LIVES_INIT = 3,
    parameter int          TICK_DIV   = 50000000,
    parameter int          ROUND_SECS = 3,
    parameter int          GAME_SECS  = 99,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       hits_sel,
    input  logic             hard_mode,
    input  logic [LANES-1:0] player_in,
    output logic [LANES-1:0] lights,
    output logic [3:0]       lives,
    output logic [7:0]       score_bcd,
    output logic [7:0]       game_time_bcd,
    output logic [3:0]       round_time,
    output logic [2:0]       state,
    output logic             game_over
);

    localparam int         IDX_W    = lane_idx_w(LANES);
    localparam logic [7:0] GAME_BCD = 8'((GAME_SECS / 10) * 16 + (GAME_SECS % 10));

    logic [2:0]       state_q, state_d;
    logic [LANES-1:0] pattern_q, pattern_d;
    logic [1:0]       hits_n_q, hits_n_d;
    logic [3:0]       lives_q, lives_d;
    logic [7:0]       score_q, score_d;
    logic [7:0]       game_time_q, game_time_d;
    logic [3:0]       round_time_q, round_time_d;
    logic [31:0]      tick_cnt_q;
    logic             start_q;
    logic             start_edge;
    logic             running;
    logic             tick;
    logic             miss;
    logic [1:0]       sel_eff;
    logic [3:0]       window;
    logic [IDX_W-1:0] lane_idx;

    lane_lfsr #(
        .SEED  (LFSR_SEED),
        .IDX_W (IDX_W)
    ) u_lfsr (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .idx    (lane_idx)
    );

    assign start_edge = start & ~start_q;
    assign running    = state_q inside {ST_LOAD, ST_SHOW, ST_WAIT_CLR};
    assign tick       = running && (tick_cnt_q == 32'(TICK_DIV - 1));
    assign window     = hard_mode ? 4'(ROUND_SECS - 1) : 4'(ROUND_SECS);

    always_comb begin
        sel_eff = (hits_sel == 2'd0) ? 2'd1 : hits_sel;
        if (32'(sel_eff) > MAX_HITS) sel_eff = 2'(MAX_HITS);
    end

    // Divider only counts while a game is live, so each game starts on a fresh second.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q <= '0;
        end else if (!running || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pattern_d    = pattern_q;
        hits_n_d     = hits_n_q;
        lives_d      = lives_q;
        score_d      = score_q;
        game_time_d  = game_time_q;
        round_time_d = round_time_q;
        miss         = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    lives_d     = 4'(LIVES_INIT);
                    score_d     = 8'h00;
                    game_time_d = GAME_BCD;
                    pattern_d   = '0;
                    hits_n_d    = sel_eff;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // One new lane per cycle; an already-lit index simply waits for the next LFSR value.
                if ($countones(pattern_q) == 32'(hits_n_q)) begin
                    round_time_d = window;
                    state_d      = ST_SHOW;
                end else if (!pattern_q[lane_idx]) begin
                    pattern_d[lane_idx] = 1'b1;
                end
            end
            ST_SHOW: begin
                if (player_in == pattern_q) begin
                    score_d = bcd_inc_sat(score_q);
                    state_d = ST_WAIT_CLR;
                end else if (|(player_in & ~pattern_q)) begin
                    miss = 1'b1;
                end else if (tick) begin
                    if (round_time_q == 4'd1) miss = 1'b1;
                    else round_time_d = round_time_q - 4'd1;
                end
                if (miss) begin
                    lives_d = lives_q - 4'd1;
                    state_d = (lives_q == 4'd1) ? ST_OVER : ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                pattern_d = '0;
                if (player_in == '0) begin
                    hits_n_d = sel_eff;
                    state_d  = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Game expiry wins over whatever the round logic decided this cycle.
        if (tick) begin
            game_time_d = bcd_dec(game_time_q);
            if (game_time_q == 8'h01) state_d = ST_OVER;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pattern_q    <= '0;
            hits_n_q     <= 2'd1;
            lives_q      <= 4'd0;
            score_q      <= 8'h00;
            game_time_q  <= GAME_BCD;
            round_time_q <= 4'd0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            hits_n_q     <= hits_n_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            game_time_q  <= game_time_d;
            round_time_q <= round_time_d;
            start_q      <= start;
        end
    end

    assign lights        = (state_q == ST_SHOW) ? pattern_q : '0;
    assign lives         = lives_q;
    assign score_bcd     = score_q;
    assign game_time_bcd = game_time_q;
    assign round_time    = round_time_q;
    assign state         = state_q;
    assign game_over     = (state_q == ST_OVER);

endmodule

// File: tb/tb_lane_round_engine.sv
// Directed bench for lane_round_engine with a 10-cycle tick and a 5 s game.
module tb_lane_round_engine;

    localparam int LANES = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [1:0]       hits_sel;
    logic             hard_mode;
    logic [LANES-1:0] player_in;
    logic [LANES-1:0] lights;
    logic [3:0]       lives;
    logic [7:0]       score_bcd;
    logic [7:0]       game_time_bcd;
    logic [3:0]       round_time;
    logic [2:0]       state;
    logic             game_over;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int p0      = 0;
    int ps      = 0;

    lane_round_engine #(
        .LANES      (LANES),
        .MAX_HITS   (3),
        .LIVES_INIT (3),
        .TICK_DIV   (10),
        .ROUND_SECS (3),
        .GAME_SECS  (5)
    ) dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .start         (start),
        .hits_sel      (hits_sel),
        .hard_mode     (hard_mode),
        .player_in     (player_in),
        .lights        (lights),
        .lives         (lives),
        .score_bcd     (score_bcd),
        .game_time_bcd (game_time_bcd),
        .round_time    (round_time),
        .state         (state),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_state(input logic [2:0] target, input int limit, input string tag);
        for (int i = 0; i < limit && state !== target; i++) step();
        chk(tag, 32'(state), 32'(target));
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        p0 = cyc;
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_lights"}, 32'(lights), 32'd0);
        chk({tag, "_lives"}, 32'(lives), 32'd0);
        chk({tag, "_score"}, 32'(score_bcd), 32'h00);
        chk({tag, "_gtime"}, 32'(game_time_bcd), 32'h05);
        chk({tag, "_rtime"}, 32'(round_time), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
    endtask

    function automatic logic [LANES-1:0] outside_bit(input logic [LANES-1:0] l);
        for (int i = 0; i < LANES; i++)
            if (!l[i]) return LANES'(16'd1 << i);
        return '0;
    endfunction

    initial begin
        resetn = 1'b0; start = 1'b0; hits_sel = 2'd3; hard_mode = 1'b0; player_in = '0;
        step();
        step();
        resetn = 1'b1;
        step();
        chk_reset_vals("rst");

        // Game A: three lanes, a hit, then three wrong-lane misses to OVER.
        start_game();
        chk("a_load", 32'(state), 32'd1);
        wait_state(3'd2, 40, "a_show");
        ps = cyc;
        chk("a_pop3", 32'($countones(lights)), 32'd3);
        chk("a_lives", 32'(lives), 32'd3);
        chk("a_score", 32'(score_bcd), 32'h00);
        chk("a_gtime", 32'(game_time_bcd), 32'(5 - (ps - p0) / 10));
        chk("a_rtime", 32'(round_time), 32'd3);

        player_in = lights;
        hits_sel = 2'd1;
        step();
        chk("hit_state", 32'(state), 32'd3);
        chk("hit_score", 32'(score_bcd), 32'h01);
        chk("hit_lights", 32'(lights), 32'd0);
        step();
        step();
        chk("hold_wait", 32'(state), 32'd3);
        player_in = '0;
        step();
        chk("clr_load", 32'(state), 32'd1);
        wait_state(3'd2, 10, "a_show2");
        chk("a_pop1", 32'($countones(lights)), 32'd1);

        for (int r = 0; r < 3; r++) begin
            player_in = outside_bit(lights);
            hits_sel = 2'd0;
            step();
            chk("miss_lives", 32'(lives), 32'(2 - r));
            if (r < 2) begin
                chk("miss_wait", 32'(state), 32'd3);
                player_in = '0;
                wait_state(3'd2, 10, "a_reshow");
                chk("sel0_pop1", 32'($countones(lights)), 32'd1);
            end
        end
        chk("a_over_state", 32'(state), 32'd4);
        chk("a_over_flag", 32'(game_over), 32'd1);
        chk("a_over_lights", 32'(lights), 32'd0);
        chk("a_over_score", 32'(score_bcd), 32'h01);
        player_in = '0;

        // Game B: restart from OVER, single lane, round timeout, then async reset mid-SHOW.
        hits_sel = 2'd0;
        start_game();
        chk("b_load", 32'(state), 32'd1);
        chk("b_lives", 32'(lives), 32'd3);
        chk("b_score", 32'(score_bcd), 32'h00);
        chk("b_gtime", 32'(game_time_bcd), 32'h05);
        chk("b_over", 32'(game_over), 32'd0);
        run_to(p0 + 2);
        chk("b_show", 32'(state), 32'd2);
        chk("b_pop1", 32'($countones(lights)), 32'd1);
        chk("b_rtime", 32'(round_time), 32'd3);
        run_to(p0 + 29);
        chk("to_pre_state", 32'(state), 32'd2);
        chk("to_pre_rtime", 32'(round_time), 32'd1);
        chk("to_pre_lives", 32'(lives), 32'd3);
        chk("to_pre_gtime", 32'(game_time_bcd), 32'h03);
        step();
        chk("to_state", 32'(state), 32'd3);
        chk("to_lives", 32'(lives), 32'd2);
        chk("to_gtime", 32'(game_time_bcd), 32'h02);
        run_to(p0 + 33);
        chk("b_show2", 32'(state), 32'd2);
        #3;
        resetn = 1'b0;
        #1;
        chk_reset_vals("async");
        resetn = 1'b1;
        step();

        // Game C: hard mode windows, then a hit on the expiry tick.
        hard_mode = 1'b1;
        hits_sel = 2'd1;
        start_game();
        run_to(p0 + 2);
        chk("c_show", 32'(state), 32'd2);
        chk("c_rtime", 32'(round_time), 32'd2);
        run_to(p0 + 19);
        chk("hd_pre_state", 32'(state), 32'd2);
        chk("hd_pre_rtime", 32'(round_time), 32'd1);
        step();
        chk("hd_state", 32'(state), 32'd3);
        chk("hd_lives", 32'(lives), 32'd2);
        chk("hd_gtime", 32'(game_time_bcd), 32'h03);
        run_to(p0 + 23);
        chk("c_show2", 32'(state), 32'd2);
        chk("c_rtime2", 32'(round_time), 32'd2);
        run_to(p0 + 40);
        chk("hd2_state", 32'(state), 32'd3);
        chk("hd2_lives", 32'(lives), 32'd1);
        chk("hd2_gtime", 32'(game_time_bcd), 32'h01);
        run_to(p0 + 49);
        chk("exp_pre_state", 32'(state), 32'd2);
        player_in = lights;
        step();
        chk("exp_state", 32'(state), 32'd4);
        chk("exp_score", 32'(score_bcd), 32'h01);
        chk("exp_gtime", 32'(game_time_bcd), 32'h00);
        chk("exp_lives", 32'(lives), 32'd1);
        chk("exp_flag", 32'(game_over), 32'd1);
        chk("exp_lights", 32'(lights), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lane_round_engine.md
Name: lane_round_engine

Overview:
- Parametrised successor to the single-pattern game core. Owns the whole round loop: random multi-lane pattern generation, per-round countdown, hit/miss judgement, lives, BCD score and BCD game timer.
- Sits between the switch/LED board I/O and the hex decoders in the top level. It replaces the separate FSM, RNG, light-mux, life-counter and score-counter instances.
- New over the previous generation:
  - configurable lane count;
  - guaranteed-distinct lit lanes (1..MAX_HITS);
  - hard mode with a shortened round window;
  - a clear-switches handshake between rounds.

Parameters:
- LANES, 16, number of lanes/switches/LEDs; power of two, 4..32.
- MAX_HITS, 3, maximum simultaneously lit lanes; must satisfy MAX_HITS <= LANES.
- LIVES_INIT, 3, lives loaded on game start (1..9).
- TICK_DIV, 50000000, clock cycles per 1 s tick.
- ROUND_SECS, 3, round window in seconds (2..9).
- GAME_SECS, 99, game length in seconds (1..99).
- LFSR_SEED, 16'hACE1, nonzero reset seed for the 16-bit LFSR.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  level input; a rising edge starts or restarts a game.
- hits_sel  in  2  requested lit lanes; 0 is treated as 1; values above MAX_HITS clamp to MAX_HITS.
- hard_mode  in  1  when 1, the round window is ROUND_SECS-1.
- player_in  in  LANES  player switches.
- lights  out  LANES  lit-lane pattern.
- lives  out  4  remaining lives, binary.
- score_bcd  out  8  two BCD digits.
- game_time_bcd  out  8  two BCD digits, counts down.
- round_time  out  4  seconds left in the current round.
- state  out  3  current FSM state code.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (async, resetn=0) values:
  - state IDLE; lights 0; lives 0; score 00; game_time GAME_SECS (BCD); round_time 0; game_over 0.
  - LFSR is loaded with LFSR_SEED; tick divider is cleared.
- Tick: a 1-cycle pulse every TICK_DIV cycles. The divider runs only in LOAD, SHOW and WAIT_CLR; it is cleared otherwise.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle regardless of state.
- start edge: registered previous value; edge = start & ~start_q.
- IDLE:
  - lights 0.
  - On start edge: lives<=LIVES_INIT, score<=00, game_time<=GAME_SECS, pattern<=0, then go to LOAD.
- LOAD: adds at most one lane per cycle.
  - idx = LFSR[log2(LANES)-1:0].
  - If pattern[idx]=0, set that bit; otherwise retry next cycle.
  - When popcount(pattern) == N (effective hits_sel, sampled on entry to LOAD): round_time<=window, go to SHOW.
  - lights = 0 during LOAD.
- SHOW: lights = pattern. Priority each cycle:
  1. player_in == pattern: HIT. Score +1 BCD, saturating at 99. Go to WAIT_CLR.
  2. player_in & ~pattern != 0: MISS.
  3. Tick with round_time == 1: MISS (timeout). Otherwise a tick decrements round_time.
- MISS:
  - lives decrements.
  - If lives was 1: go to OVER (lives=0).
  - Otherwise: go to WAIT_CLR.
- WAIT_CLR:
  - lights 0; pattern cleared.
  - Stays until player_in == 0, then goes to LOAD.
- Game timer:
  - Decrements in BCD on each tick while in LOAD, SHOW or WAIT_CLR.
  - On the tick where it goes 01 -> 00, the next state is OVER, overriding any other transition.
  - A HIT scored in the same cycle still counts.
  - A MISS in the same cycle still decrements lives.
- OVER:
  - game_over=1; lights 0; all counters hold.
  - On start edge, behaves exactly like the IDLE start.
- start edge while in LOAD, SHOW or WAIT_CLR: ignored.
- State codes: IDLE=0, LOAD=1, SHOW=2, WAIT_CLR=3, OVER=4.
- Window: ROUND_SECS, or ROUND_SECS-1 if hard_mode. hard_mode is sampled on LOAD exit.

Decomposition:
- Shared package holds:
  - state enum/codes;
  - LFSR tap constant;
  - BCD increment/decrement functions;
  - the clog2-based lane index width.
- One sub-module, lane_lfsr: 16-bit LFSR with seed parameter, async active-low reset, free-running.
- Tick divider, BCD counters and FSM live in the top body.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=10, LANES=16, MAX_HITS=3, LIVES_INIT=3, ROUND_SECS=3, GAME_SECS=5.
- Reset then start edge, hits_sel=3 -> within ≤40 cycles state=SHOW, popcount(lights)=3, lives=3, score=00, game_time=05.
- In SHOW drive player_in=lights -> next cycle state=WAIT_CLR, score=01. Hold player_in -> stays in WAIT_CLR. player_in=0 -> state=LOAD.
- In SHOW drive one bit outside lights -> lives 3->2, WAIT_CLR. Repeat twice more -> lives=0, state=OVER, game_over=1, lights=0.
- No input, hard_mode=0 -> MISS exactly 3 ticks (30 cycles) after SHOW entry. hard_mode=1 -> after 2 ticks.
- Play through with no misses -> after 5 ticks game_time=00, state=OVER. Hit on the same cycle as expiry -> score incremented and OVER.
- Assert resetn mid-SHOW -> outputs return to reset values immediately. hits_sel=0 -> exactly 1 lit lane.
